board_move_writer: RTL and testbench

- Sequential writer of the 18-bit tic-tac-toe board word consumed by board_state_checker.
- Accepts player moves (square index 0-8), validates them, and writes the 2-bit square encoding.
- Alternates turns, waits for the checker's X_win/O_win/tie feedback, and latches the game result.
- Sits between the input/debounce logic and the checker/display path.

---
 rtl/board_move_writer.sv | 178 +++++++++++++++++
 tb/tb_board_move_writer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/board_move_writer.sv
// Tic-tac-toe move writer: validates player moves, builds the 18-bit board word and latches the result.
// Optional per-turn timeout (timeout_pulse port, TIMEOUT_CYCLES parameter) is enabled by defining MOVE_TIMEOUT_EN.
module board_move_writer #(
    parameter bit FIRST_X = 1'b1
`ifdef MOVE_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 500000000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_game,
    input  logic        move_valid,
    input  logic [3:0]  move_pos,
    input  logic        X_win,
    input  logic        O_win,
    input  logic        tie,
    output logic [17:0] board_out,
    output logic        move_ready,
    output logic        turn_x,
    output logic        move_accept,
    output logic        move_reject,
    output logic [3:0]  move_count,
    output logic        game_over,
`ifdef MOVE_TIMEOUT_EN
    output logic        timeout_pulse,
`endif
    output logic [1:0]  result
);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        OVER  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic [3:0]  count_q, count_d;
    logic        turn_x_q, turn_x_d;
    logic        accept_q, accept_d;
    logic        reject_q, reject_d;
    logic [1:0]  result_q, result_d;
    logic [15:0] occupied;
    logic [1:0]  piece;

`ifdef MOVE_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tpulse_q, tpulse_d;
`endif

    // Positions 9-15 read as occupied so a single lookup covers both illegal-move cases.
    always_comb begin
        occupied = '1;
        for (int k = 0; k < 9; k++) begin
            occupied[k] = board_q[17-2*k];
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d  = state_q;
        board_d  = board_q;
        count_d  = count_q;
        turn_x_d = turn_x_q;
        result_d = result_q;
        accept_d = 1'b0;
        reject_d = 1'b0;
        piece    = turn_x_q ? 2'b11 : 2'b10;
`ifdef MOVE_TIMEOUT_EN
        tcnt_d   = tcnt_q;
        tpulse_d = 1'b0;
`endif

        unique case (state_q)
            PLAY: begin
                if (move_valid && !occupied[move_pos]) begin
                    for (int k = 0; k < 9; k++) begin
                        if (move_pos == 4'(k)) begin
                            board_d[17-2*k -: 2] = piece;
                        end
                    end
                    count_d  = (count_q == 4'd9) ? count_q : count_q + 4'd1;
                    accept_d = 1'b1;
                    state_d  = CHECK;
                end else begin
                    reject_d = move_valid;
`ifdef MOVE_TIMEOUT_EN
                    if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        turn_x_d = !turn_x_q;
                        tcnt_d   = '0;
                        tpulse_d = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
`endif
                end
            end
            CHECK: begin
                state_d = OVER;
                // A full board with no win flagged is a tie even if the checker stays silent.
                if (X_win) begin
                    result_d = 2'b01;
                end else if (O_win) begin
                    result_d = 2'b10;
                end else if (tie || count_q == 4'd9) begin
                    result_d = 2'b11;
                end else begin
                    turn_x_d = !turn_x_q;
                    state_d  = PLAY;
`ifdef MOVE_TIMEOUT_EN
                    tcnt_d   = '0;
`endif
                end
            end
            OVER: begin
            end
            default: state_d = PLAY;
        endcase

        if (new_game) begin
            state_d  = PLAY;
            board_d  = '0;
            count_d  = '0;
            turn_x_d = FIRST_X;
            result_d = 2'b00;
            accept_d = 1'b0;
            reject_d = 1'b0;
`ifdef MOVE_TIMEOUT_EN
            tcnt_d   = '0;
            tpulse_d = 1'b0;
`endif
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= PLAY;
            board_q  <= '0;
            count_q  <= '0;
            turn_x_q <= FIRST_X;
            result_q <= 2'b00;
            accept_q <= 1'b0;
            reject_q <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
            tcnt_q   <= '0;
            tpulse_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            count_q  <= count_d;
            turn_x_q <= turn_x_d;
            result_q <= result_d;
            accept_q <= accept_d;
            reject_q <= reject_d;
`ifdef MOVE_TIMEOUT_EN
            tcnt_q   <= tcnt_d;
            tpulse_q <= tpulse_d;
`endif
        end
    end

    assign board_out   = board_q;
    assign move_ready  = (state_q == PLAY);
    assign game_over   = (state_q == OVER);
    assign turn_x      = turn_x_q;
    assign move_accept = accept_q;
    assign move_reject = reject_q;
    assign move_count  = count_q;
    assign result      = result_q;
`ifdef MOVE_TIMEOUT_EN
    assign timeout_pulse = tpulse_q;
`endif

endmodule

// File: tb/tb_board_move_writer.sv
// Directed self-checking bench for board_move_writer; inputs change and outputs are sampled on the falling edge.
module tb_board_move_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        new_game = 1'b0;
    logic        move_valid = 1'b0;
    logic [3:0]  move_pos = 4'd0;
    logic        X_win = 1'b0;
    logic        O_win = 1'b0;
    logic        tie = 1'b0;
    logic [17:0] board_out;
    logic        move_ready, turn_x, move_accept, move_reject, game_over;
    logic [3:0]  move_count;
    logic [1:0]  result;
`ifdef MOVE_TIMEOUT_EN
    logic        timeout_pulse;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    board_move_writer dut (
        .clk         (clk),
        .rst         (rst),
        .new_game    (new_game),
        .move_valid  (move_valid),
        .move_pos    (move_pos),
        .X_win       (X_win),
        .O_win       (O_win),
        .tie         (tie),
        .board_out   (board_out),
        .move_ready  (move_ready),
        .turn_x      (turn_x),
        .move_accept (move_accept),
        .move_reject (move_reject),
        .move_count  (move_count),
        .game_over   (game_over),
`ifdef MOVE_TIMEOUT_EN
        .timeout_pulse (timeout_pulse),
`endif
        .result      (result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full turn: move edge, then the CHECK edge with the given checker flags.
    task automatic play_move(input logic [3:0] pos, input logic xw, input logic ow, input logic tw);
        move_valid = 1'b1;
        move_pos   = pos;
        tick();
        move_valid = 1'b0;
        X_win = xw; O_win = ow; tie = tw;
        tick();
        X_win = 1'b0; O_win = 1'b0; tie = 1'b0;
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++; if (board_out !== 18'h0) begin n_fail++; $display("FAIL reset_board: got %h want %h", board_out, 18'h0); end
        n_checks++; if (move_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", move_count); end
        n_checks++; if (result !== 2'b00) begin n_fail++; $display("FAIL reset_result: got %b want 00", result); end
        n_checks++; if (turn_x !== 1'b1) begin n_fail++; $display("FAIL reset_turn: got %b want 1", turn_x); end
        n_checks++; if (move_accept !== 1'b0 || move_reject !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got acc=%b rej=%b want 0/0", move_accept, move_reject); end
        n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL reset_over: got %b want 0", game_over); end
        n_checks++; if (move_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", move_ready); end
    endtask

    task automatic test_first_move();
        move_valid = 1'b1;
        move_pos   = 4'd4;
        tick();
        move_valid = 1'b0;
        n_checks++; if (board_out !== 18'h00300) begin n_fail++; $display("FAIL first_board: got %h want %h", board_out, 18'h00300); end
        n_checks++; if (move_accept !== 1'b1) begin n_fail++; $display("FAIL first_accept: got %b want 1", move_accept); end
        n_checks++; if (move_count !== 4'd1) begin n_fail++; $display("FAIL first_count: got %0d want 1", move_count); end
        n_checks++; if (move_ready !== 1'b0) begin n_fail++; $display("FAIL first_ready_in_check: got %b want 0", move_ready); end
        tick();
        n_checks++; if (move_accept !== 1'b0) begin n_fail++; $display("FAIL first_accept_single: got %b want 0", move_accept); end
        n_checks++; if (turn_x !== 1'b0) begin n_fail++; $display("FAIL first_turn: got %b want 0", turn_x); end
        n_checks++; if (move_ready !== 1'b1) begin n_fail++; $display("FAIL first_ready_back: got %b want 1", move_ready); end
    endtask

    task automatic test_illegal();
        move_valid = 1'b1;
        move_pos   = 4'd4;
        tick();
        n_checks++; if (move_reject !== 1'b1 || move_accept !== 1'b0) begin n_fail++; $display("FAIL occ_pulses: got acc=%b rej=%b want 0/1", move_accept, move_reject); end
        n_checks++; if (board_out !== 18'h00300) begin n_fail++; $display("FAIL occ_board: got %h want %h", board_out, 18'h00300); end
        n_checks++; if (turn_x !== 1'b0 || move_ready !== 1'b1) begin n_fail++; $display("FAIL occ_turn_ready: got turn=%b ready=%b want 0/1", turn_x, move_ready); end
        move_pos = 4'd12;
        tick();
        n_checks++; if (move_reject !== 1'b1 || move_accept !== 1'b0) begin n_fail++; $display("FAIL range_pulses: got acc=%b rej=%b want 0/1", move_accept, move_reject); end
        n_checks++; if (board_out !== 18'h00300 || move_count !== 4'd1) begin n_fail++; $display("FAIL range_board: got %h/%0d want 00300/1", board_out, move_count); end
        move_valid = 1'b0;
        tick();
        n_checks++; if (move_reject !== 1'b0) begin n_fail++; $display("FAIL reject_single: got %b want 0", move_reject); end
    endtask

    task automatic test_x_win();
        pulse_new_game();
        n_checks++; if (board_out !== 18'h0 || turn_x !== 1'b1 || move_count !== 4'd0) begin n_fail++; $display("FAIL xwin_start: got %h/%b/%0d want 0/1/0", board_out, turn_x, move_count); end
        play_move(4'd0, 1'b0, 1'b0, 1'b0);
        play_move(4'd3, 1'b0, 1'b0, 1'b0);
        play_move(4'd1, 1'b0, 1'b0, 1'b0);
        play_move(4'd4, 1'b0, 1'b0, 1'b0);
        // All three flags high: X_win must take priority.
        play_move(4'd2, 1'b1, 1'b1, 1'b1);
        n_checks++; if (result !== 2'b01) begin n_fail++; $display("FAIL xwin_result: got %b want 01", result); end
        n_checks++; if (game_over !== 1'b1 || move_ready !== 1'b0) begin n_fail++; $display("FAIL xwin_over: got over=%b ready=%b want 1/0", game_over, move_ready); end
        n_checks++; if (board_out !== 18'h3FA00) begin n_fail++; $display("FAIL xwin_board: got %h want %h", board_out, 18'h3FA00); end
        n_checks++; if (move_count !== 4'd5 || turn_x !== 1'b1) begin n_fail++; $display("FAIL xwin_count_turn: got %0d/%b want 5/1", move_count, turn_x); end
        move_valid = 1'b1;
        move_pos   = 4'd5;
        tick();
        n_checks++; if (move_accept !== 1'b0 || move_reject !== 1'b0) begin n_fail++; $display("FAIL over_ignore_pulses: got acc=%b rej=%b want 0/0", move_accept, move_reject); end
        tick();
        move_valid = 1'b0;
        n_checks++; if (board_out !== 18'h3FA00 || game_over !== 1'b1 || result !== 2'b01) begin n_fail++; $display("FAIL over_frozen: got %h/%b/%b want 3fa00/1/01", board_out, game_over, result); end
    endtask

    task automatic test_o_win();
        pulse_new_game();
        play_move(4'd0, 1'b0, 1'b0, 1'b0);
        play_move(4'd3, 1'b0, 1'b0, 1'b0);
        play_move(4'd1, 1'b0, 1'b0, 1'b0);
        play_move(4'd4, 1'b0, 1'b0, 1'b0);
        play_move(4'd8, 1'b0, 1'b0, 1'b0);
        // O_win outranks a coincident tie flag.
        play_move(4'd5, 1'b0, 1'b1, 1'b1);
        n_checks++; if (result !== 2'b10 || game_over !== 1'b1) begin n_fail++; $display("FAIL owin_result: got %b/%b want 10/1", result, game_over); end
        n_checks++; if (board_out !== 18'h3CA83) begin n_fail++; $display("FAIL owin_board: got %h want %h", board_out, 18'h3CA83); end
        n_checks++; if (move_count !== 4'd6 || turn_x !== 1'b0) begin n_fail++; $display("FAIL owin_count_turn: got %0d/%b want 6/0", move_count, turn_x); end
    endtask

    task automatic test_full_board();
        logic [3:0] seq [8];
        seq = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6};
        pulse_new_game();
        for (int i = 0; i < 8; i++) begin
            play_move(seq[i], 1'b0, 1'b0, 1'b0);
        end
        n_checks++; if (move_count !== 4'd8 || turn_x !== 1'b1 || game_over !== 1'b0) begin n_fail++; $display("FAIL tie_eight: got %0d/%b/%b want 8/1/0", move_count, turn_x, game_over); end
        // Checker stays silent on the ninth move; the full board alone forces a tie.
        play_move(4'd8, 1'b0, 1'b0, 1'b0);
        n_checks++; if (move_count !== 4'd9) begin n_fail++; $display("FAIL tie_count: got %0d want 9", move_count); end
        n_checks++; if (result !== 2'b11 || game_over !== 1'b1) begin n_fail++; $display("FAIL tie_result: got %b/%b want 11/1", result, game_over); end
        n_checks++; if (board_out !== 18'h3BEAF) begin n_fail++; $display("FAIL tie_board: got %h want %h", board_out, 18'h3BEAF); end
    endtask

    task automatic test_new_game();
        new_game   = 1'b1;
        move_valid = 1'b1;
        move_pos   = 4'd0;
        tick();
        new_game   = 1'b0;
        move_valid = 1'b0;
        n_checks++; if (board_out !== 18'h0 || move_count !== 4'd0 || result !== 2'b00) begin n_fail++; $display("FAIL ng_over_clear: got %h/%0d/%b want 0/0/00", board_out, move_count, result); end
        n_checks++; if (turn_x !== 1'b1 || move_ready !== 1'b1 || game_over !== 1'b0 || move_accept !== 1'b0) begin n_fail++; $display("FAIL ng_over_state: got turn=%b ready=%b over=%b acc=%b want 1/1/0/0", turn_x, move_ready, game_over, move_accept); end
        move_valid = 1'b1;
        move_pos   = 4'd4;
        tick();
        n_checks++; if (board_out !== 18'h00300 || move_ready !== 1'b0) begin n_fail++; $display("FAIL ng_pre_check: got %h/%b want 00300/0", board_out, move_ready); end
        new_game = 1'b1;
        move_pos = 4'd0;
        tick();
        new_game   = 1'b0;
        move_valid = 1'b0;
        n_checks++; if (board_out !== 18'h0 || move_count !== 4'd0 || move_accept !== 1'b0) begin n_fail++; $display("FAIL ng_check_clear: got %h/%0d/%b want 0/0/0", board_out, move_count, move_accept); end
        n_checks++; if (turn_x !== 1'b1 || move_ready !== 1'b1) begin n_fail++; $display("FAIL ng_check_state: got turn=%b ready=%b want 1/1", turn_x, move_ready); end
        tick();
        n_checks++; if (board_out !== 18'h0 || move_accept !== 1'b0) begin n_fail++; $display("FAIL ng_no_late_write: got %h/%b want 0/0", board_out, move_accept); end
    endtask

    task automatic test_back_to_back();
        move_valid = 1'b1;
        move_pos   = 4'd0;
        tick();
        n_checks++; if (board_out !== 18'h30000 || move_accept !== 1'b1) begin n_fail++; $display("FAIL hold_first: got %h/%b want 30000/1", board_out, move_accept); end
        tick();
        n_checks++; if (move_accept !== 1'b0 || move_reject !== 1'b0 || move_count !== 4'd1) begin n_fail++; $display("FAIL hold_in_check: got acc=%b rej=%b cnt=%0d want 0/0/1", move_accept, move_reject, move_count); end
        n_checks++; if (turn_x !== 1'b0 || board_out !== 18'h30000) begin n_fail++; $display("FAIL hold_turn: got %b/%h want 0/30000", turn_x, board_out); end
        tick();
        move_valid = 1'b0;
        n_checks++; if (move_reject !== 1'b1 || move_count !== 4'd1) begin n_fail++; $display("FAIL hold_second_reject: got rej=%b cnt=%0d want 1/1", move_reject, move_count); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_move();
        test_illegal();
        test_x_win();
        test_o_win();
        test_full_board();
        test_new_game();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
